// File: rtl/mc_controller.sv
// Multicycle control FSM for the 8-bit MIPS datapath: byte-wise fetch, decode, execute.
// Define MC_ADDI_EN to add addi support (ADDIEX/ADDIWR states).
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       iord,
    output logic [3:0] irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       pcen,
    output logic [1:0] pcsource,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    typedef enum logic [3:0] {
        FETCH1  = 4'd0,
        FETCH2  = 4'd1,
        FETCH3  = 4'd2,
        FETCH4  = 4'd3,
        DECODE  = 4'd4,
        MEMADR  = 4'd5,
        LBRD    = 4'd6,
        LBWR    = 4'd7,
        SBWR    = 4'd8,
        RTYPEEX = 4'd9,
        RTYPEWR = 4'd10,
        BEQEX   = 4'd11,
        JEX     = 4'd12
`ifdef MC_ADDI_EN
        ,
        ADDIEX  = 4'd13,
        ADDIWR  = 4'd14
`endif
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic       mem_rd;
    logic       mem_wr;
    logic [3:0] ir_wr;
    logic       reg_wr;
    logic       pcwrite;
    logic       branch;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= FETCH1;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH1;
        case (state_q)
            FETCH1:  state_d = FETCH2;
            FETCH2:  state_d = FETCH3;
            FETCH3:  state_d = FETCH4;
            FETCH4:  state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LB, OP_SB: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_J:         state_d = JEX;
`ifdef MC_ADDI_EN
                    OP_ADDI:      state_d = ADDIEX;
`endif
                    default:      state_d = FETCH1;
                endcase
            end
            MEMADR: begin
                if (op == OP_LB)
                    state_d = LBRD;
                else if (op == OP_SB)
                    state_d = SBWR;
                else
                    state_d = FETCH1;
            end
            LBRD:    state_d = LBWR;
            RTYPEEX: state_d = RTYPEWR;
`ifdef MC_ADDI_EN
            ADDIEX:  state_d = ADDIWR;
`endif
            default: state_d = FETCH1;
        endcase
    end

    always_comb begin
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        iord       = 1'b0;
        ir_wr      = 4'b0000;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        reg_wr     = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        pcsource   = 2'b00;
        alucontrol = 3'b010;
        case (state_q)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
                mem_rd  = 1'b1;
                alusrcb = 2'b01;
                pcwrite = 1'b1;
                // FETCH1..FETCH4 are encodings 0..3, so the low bits select the byte lane
                ir_wr   = 4'b0001 << state_q[1:0];
            end
            DECODE: alusrcb = 2'b11;
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            LBRD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
            end
            LBWR: begin
                reg_wr   = 1'b1;
                memtoreg = 1'b1;
            end
            SBWR: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            RTYPEWR: begin
                reg_wr = 1'b1;
                regdst = 1'b1;
            end
            BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsource   = 2'b01;
                branch     = 1'b1;
            end
            JEX: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
`ifdef MC_ADDI_EN
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWR: reg_wr = 1'b1;
`endif
            default: ;
        endcase
    end

    // Strobes are masked while reset is low, since the held FETCH1 state would otherwise drive them
    assign memread  = mem_rd & reset;
    assign memwrite = mem_wr & reset;
    assign regwrite = reg_wr & reset;
    assign irwrite  = reset ? ir_wr : 4'b0000;
    assign pcen     = (pcwrite | (branch & zero)) & reset;
    assign state    = state_q;

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control FSM for the 8-bit MIPS datapath.
- Fetches each 32-bit instruction as four byte reads, MSB first (irwrite[0] loads instr[31:24]).
- Decodes op/funct and drives every datapath select and enable, plus memory read/write strobes.
- Supported instructions: lb, sb, R-type (add/sub/and/or/slt), beq, j; addi optional.

Parameters:
- None. State encoding is fixed as listed under Behaviour.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- op  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag from datapath
- memread  out  1  memory read strobe
- memwrite  out  1  memory write strobe
- alusrca  out  1  0=PC, 1=register A
- alusrcb  out  2  00=reg B, 01=const 1, 10=instr[7:0], 11=constx4
- iord  out  1  0=PC address, 1=aluout address
- irwrite  out  4  one-hot instruction byte load
- memtoreg  out  1  1=memory data, 0=aluout
- regdst  out  1  1=rd instr[13:11], 0=rt instr[18:16]
- regwrite  out  1  register file write
- pcen  out  1  PC load = pcwrite | (branch & zero)
- pcsource  out  2  00=aluresult, 01=aluout, 10=constx4
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- state  out  4  current state, for debug/verification

Behaviour:
- Single 4-bit state register. Outputs are decoded combinationally from the state; pcen additionally uses zero.
- Reset low: state goes to FETCH1 asynchronously, and memread, memwrite, irwrite, regwrite and pcen are forced to 0. The first fetch occurs on the first rising edge after reset is released.
- Any output not listed for a state is 0; alucontrol defaults to 010.
- Opcodes: lb 100000, sb 101000, R-type 000000, beq 000100, j 000010, addi 001000.
- State encodings and outputs:
  - FETCH1 (0) to FETCH4 (3): memread=1, iord=0, alusrca=0, alusrcb=01, add, pcsource=00, pcwrite=1. irwrite = 0001, 0010, 0100, 1000 respectively.
  - DECODE (4): alusrca=0, alusrcb=11, add. Puts the branch target into aluout.
  - MEMADR (5): alusrca=1, alusrcb=10, add.
  - LBRD (6): memread=1, iord=1.
  - LBWR (7): regwrite=1, memtoreg=1, regdst=0.
  - SBWR (8): memwrite=1, iord=1.
  - RTYPEEX (9): alusrca=1, alusrcb=00, alucontrol from funct.
  - RTYPEWR (10): regwrite=1, regdst=1, memtoreg=0.
  - BEQEX (11): alusrca=1, alusrcb=00, sub, pcsource=01, branch=1.
  - JEX (12): pcwrite=1, pcsource=10.
  - ADDIEX (13): alusrca=1, alusrcb=10, add.
  - ADDIWR (14): regwrite=1, regdst=0, memtoreg=0.
  - Encoding 15 is unused and goes to FETCH1.
- Transitions:
  - FETCH1→FETCH2→FETCH3→FETCH4→DECODE.
  - DECODE: lb/sb→MEMADR, R-type→RTYPEEX, beq→BEQEX, j→JEX, addi→ADDIEX; any other opcode→FETCH1 (treated as a no-op).
  - MEMADR: lb→LBRD, sb→SBWR.
  - LBRD→LBWR.
  - RTYPEEX→RTYPEWR.
  - ADDIEX→ADDIWR.
  - LBWR, SBWR, RTYPEWR, BEQEX, JEX, ADDIWR→FETCH1.
- funct decode: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other funct→010 (add).
- Latency in cycles: lb 8; sb, R-type, addi 7; beq, j 6.
- Reset asserted mid-instruction: the instruction is abandoned with no further writes.
- In BEQEX, pcen follows zero combinationally within the cycle.

Optional Feature:
- Macro: MC_ADDI_EN.
- Defined: addi is supported via ADDIEX and ADDIWR as specified above.
- Undefined: ADDIEX and ADDIWR do not exist. Opcode 001000 in DECODE goes to FETCH1 with no register write.

Test Plan:
- Reset: hold reset=0 for 3 cycles → state=0, pcen=0, irwrite=0000, memread=0. Release reset → next cycle state=1 after edge; during FETCH1 irwrite=0001, pcen=1.
- R-type: op=000000, funct=101010 → sequence 0,1,2,3,4,9,10,0; alucontrol=111 in state 9; regwrite=1 and regdst=1 in state 10.
- lb then sb: lb (op=100000) → states 4,5,6,7 with iord=1 in state 6 and memtoreg=1 in state 7. sb (op=101000) → states 4,5,8 with memwrite=1.
- beq: op=000100 with zero=1 → pcen=1 and pcsource=01 in state 11. Same with zero=0 → pcen=0.
- j and illegal opcode: op=000010 → state 12, pcen=1, pcsource=10. op=111111 → DECODE then FETCH1, with no regwrite or memwrite.
- Feature: op=001000 with MC_ADDI_EN defined → states 13,14, regwrite=1, regdst=0. Without the macro → 4 then 0, regwrite never asserted.
